path_delay_probe: RTL and testbench
===================================

PATH_DELAY_PROBE -- requirements
Module: path_delay_probe

Interface
REQ-001 Parameter CNT_W, default 16: width of the trial counter and the error counter.
REQ-002 Parameter WAIT_W, default 4: width of the capture-delay field.
REQ-003 Parameter SETTLE_CYC, default 8: idle cycles between a capture and the next launch; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  request a measurement run; sampled only in IDLE.
REQ-007 trials_i  input  CNT_W  number of launch/capture trials in the run.
REQ-008 capture_dly_i  input  WAIT_W  clock edges from launch to capture.
REQ-009 launch_o  output  1  registered drive into the input of the path under test.
REQ-010 path_i  input  1  output of the path under test; sampled directly with no synchronizer, because timing failure is the quantity measured.
REQ-011 busy_o  output  1  high while a run is in progress.
REQ-012 done_o  output  1  one-cycle pulse at the end of a run.
REQ-013 err_cnt_o  output  CNT_W  number of failed captures in the current or last run.
REQ-014 last_ok_o  output  1  result of the most recent capture (1 = matched).

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, WAIT, SETTLE and DONE.
REQ-016 IDLE with start_i=1 SHALL, on the edge:
- latch trials_i and capture_dly_i (a value of 0 is treated as 1);
- clear err_cnt_o and the trial counter;
- go to LAUNCH if trials_i != 0, else go to DONE.
REQ-017 LAUNCH SHALL, on the edge:
- toggle launch_o;
- set expected <= new launch_o (the path is non-inverting);
- load wait_cnt <= effective delay - 1;
- go to WAIT.
REQ-018 WAIT with wait_cnt != 0 SHALL decrement wait_cnt on each edge.
REQ-019 WAIT with wait_cnt == 0 SHALL, on that edge (the capture edge):
- compare path_i with expected;
- set last_ok_o to the comparison result;
- increment err_cnt_o on a mismatch;
- increment the trial counter;
- load settle_cnt <= SETTLE_CYC - 1;
- go to SETTLE.
REQ-020 Capture timing: the capture edge SHALL occur exactly D edges after the launch edge, where D is the effective delay.
REQ-021 SETTLE SHALL decrement settle_cnt on each edge. At 0 it SHALL go to DONE if trial count == latched trials, else to LAUNCH.
REQ-022 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-023 busy_o SHALL be high in LAUNCH, WAIT and SETTLE, and low in IDLE and DONE.
REQ-024 err_cnt_o and last_ok_o SHALL hold their values after DONE until the next accepted start.
REQ-025 err_cnt_o SHALL NOT exceed the latched trials value, so no wrap-around is possible.
REQ-026 start_i SHALL be ignored outside IDLE. An input change during a run SHALL NOT affect that run.
REQ-027 launch_o SHALL NOT be reset between runs; each run continues toggling from its current level.

Reset
REQ-028 rst_n low SHALL immediately force all of the following, including mid-run, with no done_o pulse:
- state IDLE;
- launch_o=0, expected=0;
- busy_o=0, done_o=0;
- err_cnt_o=0, last_ok_o=0;
- all internal counters 0.
REQ-029 After rst_n deasserts, the first start_i SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro PATH_DELAY_PROBE_FIRST_FAIL_EN, when defined, SHALL add output first_fail_o [CNT_W] carrying the 1-based index of the first failing trial in the run, with 0 meaning no failure. It is cleared at start and by reset, and updated only on the first mismatch.
REQ-031 Without PATH_DELAY_PROBE_FIRST_FAIL_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Path modelled as a 0-cycle wire, trials=4, dly=1, SETTLE_CYC=8:
- launch_o toggles 4 times, 10 cycles apart;
- done_o pulses once;
- err_cnt_o=0, last_ok_o=1.
REQ-033 Path modelled as a 2-cycle register chain, trials=3:
- dly=1 gives err_cnt_o=3, last_ok_o=0, first_fail_o=1 when the macro is enabled;
- dly=3 gives err_cnt_o=0.
REQ-034 trials=0 -> done_o pulses 1 cycle after start is accepted, busy_o never rises, launch_o unchanged, err_cnt_o=0.
REQ-035 capture_dly=0 behaves identically to capture_dly=1 (same capture edge, same counts).
REQ-036 rst_n pulsed low during WAIT of trial 2 of 5 -> all outputs zero asynchronously, no done_o pulse; a subsequent start with trials=2 completes normally.
REQ-037 start_i held high through an entire trials=2 run -> exactly one run per IDLE visit, and a new run begins the edge after DONE.

Source files
------------

// File: rtl/path_delay_probe_if.sv
// Control/status bundle for path_delay_probe.
// The probe sits on the slave modport; whoever requests runs sits on master.
// The first_fail_o field exists only when PATH_DELAY_PROBE_FIRST_FAIL_EN is defined.
interface path_delay_probe_if #(
    parameter int CNT_W  = 16,
    parameter int WAIT_W = 4
);
    logic              start_i;
    logic [CNT_W-1:0]  trials_i;
    logic [WAIT_W-1:0] capture_dly_i;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  err_cnt_o;
    logic              last_ok_o;
`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
    logic [CNT_W-1:0]  first_fail_o;

    modport master (
        output start_i, trials_i, capture_dly_i,
        input  busy_o, done_o, err_cnt_o, last_ok_o, first_fail_o
    );

    modport slave (
        input  start_i, trials_i, capture_dly_i,
        output busy_o, done_o, err_cnt_o, last_ok_o, first_fail_o
    );
`else
    modport master (
        output start_i, trials_i, capture_dly_i,
        input  busy_o, done_o, err_cnt_o, last_ok_o
    );

    modport slave (
        input  start_i, trials_i, capture_dly_i,
        output busy_o, done_o, err_cnt_o, last_ok_o
    );
`endif
endinterface

// File: rtl/path_delay_probe.sv
// path_delay_probe: launches a toggle into a path under test, captures the
// path output a programmable number of edges later and counts mismatches.
// Optional feature macro: PATH_DELAY_PROBE_FIRST_FAIL_EN adds first_fail_o,
// the 1-based index of the first failing trial of a run (0 = none).
module path_delay_probe #(
    parameter int CNT_W      = 16,
    parameter int WAIT_W     = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    path_delay_probe_if.slave     ctl,
    output logic                  launch_o,
    input  logic                  path_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1'b1);

    // A programmed delay of zero is treated as a one-edge delay.
    function automatic logic [WAIT_W-1:0] eff_dly(input logic [WAIT_W-1:0] d);
        logic [WAIT_W-1:0] r;
        if (d == {WAIT_W{1'b0}}) begin
            r = WAIT_ONE;
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   trials_r;
    logic [CNT_W-1:0]   trial_cnt_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [WAIT_W-1:0]  dly_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [7:0]         settle_cnt_r;
    logic               launch_r;
    logic               expected_r;
    logic               last_ok_r;
    logic               busy_r;
    logic               done_r;
    logic               match_s;

    // path_i is sampled raw on purpose: a late path must be seen as a mismatch.
    assign match_s = (path_i == expected_r);

`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
    logic [CNT_W-1:0]   first_fail_r;

    // First failing trial index, cleared on each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_r <= {CNT_W{1'b0}};
        end else if (state_r == S_IDLE && ctl.start_i) begin
            first_fail_r <= {CNT_W{1'b0}};
        end else if (state_r == S_WAIT && wait_cnt_r == {WAIT_W{1'b0}} &&
                     !match_s && first_fail_r == {CNT_W{1'b0}}) begin
            first_fail_r <= trial_cnt_r + CNT_ONE;
        end else begin
            first_fail_r <= first_fail_r;
        end
    end

    assign ctl.first_fail_o = first_fail_r;
`endif

    // Measurement sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            trials_r     <= {CNT_W{1'b0}};
            trial_cnt_r  <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
            dly_r        <= {WAIT_W{1'b0}};
            wait_cnt_r   <= {WAIT_W{1'b0}};
            settle_cnt_r <= 8'd0;
            launch_r     <= 1'b0;
            expected_r   <= 1'b0;
            last_ok_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (ctl.start_i) begin
                        trials_r    <= ctl.trials_i;
                        dly_r       <= eff_dly(ctl.capture_dly_i);
                        err_cnt_r   <= {CNT_W{1'b0}};
                        trial_cnt_r <= {CNT_W{1'b0}};
                        if (ctl.trials_i != {CNT_W{1'b0}}) begin
                            state_r <= S_LAUNCH;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    // Non-inverting path: expect the new launch level back.
                    launch_r   <= ~launch_r;
                    expected_r <= ~launch_r;
                    wait_cnt_r <= dly_r - WAIT_ONE;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_r != {WAIT_W{1'b0}}) begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end else begin
                        // Capture edge: exactly dly_r edges after launch.
                        last_ok_r    <= match_s;
                        if (!match_s) begin
                            err_cnt_r <= err_cnt_r + CNT_ONE;
                        end else begin
                            err_cnt_r <= err_cnt_r;
                        end
                        trial_cnt_r  <= trial_cnt_r + CNT_ONE;
                        settle_cnt_r <= SETTLE_LAST;
                        state_r      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_r != 8'd0) begin
                        settle_cnt_r <= settle_cnt_r - 8'd1;
                    end else if (trial_cnt_r == trials_r) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign launch_o      = launch_r;
    assign ctl.busy_o    = busy_r;
    assign ctl.done_o    = done_r;
    assign ctl.err_cnt_o = err_cnt_r;
    assign ctl.last_ok_o = last_ok_r;

endmodule

// File: tb/tb_path_delay_probe.sv
// Scoreboard bench for path_delay_probe: the stimulus side predicts each run
// from the measurement rules and queues the result; a negedge monitor pops
// and compares whenever done_o is seen.
module tb_path_delay_probe;

    localparam int CNT_W  = 16;
    localparam int WAIT_W = 4;
    localparam int SETTLE = 8;

    typedef struct {
        logic [CNT_W-1:0] err;
        logic             last_ok;
        logic             launch;
        int               busy;
        int               toggles;
        logic [CNT_W-1:0] ff;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       launch_o;
    logic       path_i;
    logic [2:0] chain = 3'b000;
    logic [1:0] depth = 2'd0;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   busy_seen = 0;
    int   tog_seen = 0;
    int   done_seen = 0;
    logic prev_launch = 1'b0;
    logic m_launch = 1'b0;
    logic m_last_ok = 1'b0;

    path_delay_probe_if #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) bus ();

    path_delay_probe #(
        .CNT_W(CNT_W), .WAIT_W(WAIT_W), .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctl(bus.slave),
        .launch_o(launch_o), .path_i(path_i)
    );

    always #5 clk = ~clk;

    // Path under test: a wire or a 1..3 stage register chain.
    always @(posedge clk) chain <= {chain[1:0], launch_o};

    always_comb begin
        case (depth)
            2'd0:    path_i = launch_o;
            2'd1:    path_i = chain[0];
            2'd2:    path_i = chain[1];
            default: path_i = chain[2];
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level reference: every trial of a run behaves alike, and a capture
    // matches only when the effective delay exceeds the path's latency.
    task automatic predict(input int n, input int d, input int dep, output exp_t e);
        int de;
        bit ok;
        de = (d == 0) ? 1 : d;
        ok = (de > dep);
        e.err     = ok ? CNT_W'(0) : CNT_W'(n);
        e.last_ok = (n == 0) ? m_last_ok : ok;
        e.launch  = m_launch ^ n[0];
        e.busy    = n * (1 + de + SETTLE);
        e.toggles = n;
        e.ff      = (!ok && n > 0) ? CNT_W'(1) : CNT_W'(0);
        m_launch  = e.launch;
        m_last_ok = e.last_ok;
    endtask

    // Monitor: accumulate activity per run, compare on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_seen   = 0;
            tog_seen    = 0;
            prev_launch = launch_o;
        end else begin
            if (bus.busy_o) busy_seen++;
            if (launch_o !== prev_launch) tog_seen++;
            prev_launch = launch_o;
            if (bus.done_o) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected no run pending at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("err_cnt", 32'(bus.err_cnt_o), 32'(mon_e.err));
                    check("last_ok", 32'(bus.last_ok_o), 32'(mon_e.last_ok));
                    check("launch_level", 32'(launch_o), 32'(mon_e.launch));
                    check("busy_cycles", busy_seen, mon_e.busy);
                    check("launch_toggles", tog_seen, mon_e.toggles);
                    check("busy_in_done", 32'(bus.busy_o), 32'd0);
`ifdef PATH_DELAY_PROBE_FIRST_FAIL_EN
                    check("first_fail", 32'(bus.first_fail_o), 32'(mon_e.ff));
`endif
                end
                busy_seen = 0;
                tog_seen  = 0;
            end
        end
    end

    // Bounded wait for done_o; optionally scrambles inputs during the run.
    task automatic wait_done(input bit scr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.done_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (scr) begin
                bus.trials_i      = CNT_W'($urandom);
                bus.capture_dly_i = WAIT_W'($urandom);
                bus.start_i       = 1'($urandom);
            end
        end
        bus.start_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o expected done within 3000 cycles");
        end
    endtask

    task automatic run(input int n, input int d, input int dep, input bit scr);
        exp_t e;
        depth = 2'(dep);
        predict(n, d, dep, e);
        sb.push_back(e);
        bus.trials_i      = CNT_W'(n);
        bus.capture_dly_i = WAIT_W'(d);
        bus.start_i       = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        if (n == 0) begin
            check("zero_trial_done", 32'(bus.done_o), 32'd1);
            check("zero_trial_busy", 32'(bus.busy_o), 32'd0);
        end
        wait_done(scr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e1, e2;
        int dc;
        bus.start_i       = 1'b0;
        bus.trials_i      = CNT_W'(0);
        bus.capture_dly_i = WAIT_W'(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_launch", 32'(launch_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_err", 32'(bus.err_cnt_o), 32'd0);
        check("rst_last_ok", 32'(bus.last_ok_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases: wire path, slow path, zero trials, zero delay.
        run(4, 1, 0, 1'b0);
        run(3, 1, 2, 1'b0);
        run(3, 3, 2, 1'b0);
        run(3, 2, 2, 1'b0);
        run(0, 5, 0, 1'b0);
        run(2, 0, 1, 1'b0);
        run(2, 1, 1, 1'b0);
        run(1, 15, 3, 1'b0);

        // Randomized runs with inputs scrambled while busy.
        for (int k = 0; k < 20; k++) begin
            run(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'b1);
        end

        // start_i held through back-to-back runs.
        depth = 2'd0;
        predict(2, 1, 0, e1);
        predict(2, 1, 0, e2);
        sb.push_back(e1);
        sb.push_back(e2);
        bus.trials_i      = CNT_W'(2);
        bus.capture_dly_i = WAIT_W'(1);
        bus.start_i       = 1'b1;
        wait_done(1'b0);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        check("held_idle_gap", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        check("held_restart", 32'(bus.busy_o), 32'd1);
        wait_done(1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("held_no_third_run", 32'(bus.busy_o), 32'd0);

        // Reset during WAIT of trial 2 of 5.
        if (m_launch == 1'b0) run(1, 1, 0, 1'b0);
        depth = 2'd0;
        predict(5, 2, 0, e1);
        sb.push_back(e1);
        bus.trials_i      = CNT_W'(5);
        bus.capture_dly_i = WAIT_W'(2);
        bus.start_i       = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_launch", 32'(launch_o), 32'd1);
        check("pre_rst_last_ok", 32'(bus.last_ok_o), 32'd1);
        dc = done_seen;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        check("arst_done", 32'(bus.done_o), 32'd0);
        check("arst_launch", 32'(launch_o), 32'd0);
        check("arst_err", 32'(bus.err_cnt_o), 32'd0);
        check("arst_last_ok", 32'(bus.last_ok_o), 32'd0);
        sb.delete();
        m_launch  = 1'b0;
        m_last_ok = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("no_done_on_reset", done_seen, dc);
        predict(2, 1, 0, e1);
        sb.push_back(e1);
        bus.trials_i      = CNT_W'(2);
        bus.capture_dly_i = WAIT_W'(1);
        bus.start_i       = 1'b1;
        rst_n             = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("first_edge_accept", 32'(bus.busy_o), 32'd1);
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
